// File: rtl/pipe_stage_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_pkg
//   Shared CPU pipeline constants used by every pipe_stage_skid instance
//   (IF/ID today, EX/MEM and later boundaries reuse the same values).
//   Holds:
//     CPU_INST_W / CPU_ADDR_W : default instruction and PC widths
//     CPU_NOP_INST            : bubble instruction injected on reset/flush/empty
//     skid_state_e            : 2-bit occupancy state encoding (EMPTY=0, ONE=1, TWO=2)
//     state_occupancy()       : maps a state to the number of held entries
// ---------------------------------------------------------------------------
package pipe_stage_skid_pkg;

  localparam int unsigned CPU_INST_W   = 32;
  localparam int unsigned CPU_ADDR_W   = 32;
  localparam logic [31:0] CPU_NOP_INST = 32'h0000_0000;

  // The encoding doubles as the entry count, so occupancy is the raw state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Number of held entries for a given state; the unused code reads as empty.
  function automatic logic [1:0] state_occupancy(input skid_state_e s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Flow-controlled pipeline stage register built as a 2-entry skid buffer
//   carrying {inst, pc}. Full throughput while downstream is ready; when
//   downstream stalls, one extra entry is absorbed into the skid slot and
//   in_ready drops on the following cycle. Every output is driven straight
//   from a flop, so there is no combinational path from any input to any
//   output (in particular none from out_ready to in_ready).
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset (priority over flush)
//   flush      in   synchronous kill of all held entries (redirect)
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage can accept an entry (registered)
//   in_inst    in   upstream instruction
//   in_pc      in   PC of in_inst
//   out_valid  out  out_inst/out_pc hold a valid entry (registered)
//   out_ready  in   downstream accepts the head entry; low means stall
//   out_inst   out  head instruction (NOP_INST when empty)
//   out_pc     out  head PC (zero when empty)
//   occupancy  out  held entries, 0..2 (registered)
// ---------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned           INST_W   = CPU_INST_W,
  parameter int unsigned           ADDR_W   = CPU_ADDR_W,
  parameter logic [INST_W-1:0]     NOP_INST = INST_W'(CPU_NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        occupancy
);

  localparam logic [ADDR_W-1:0] BUBBLE_PC = {ADDR_W{1'b0}};

  // Registered state and storage
  skid_state_e       r_state;
  logic [INST_W-1:0] r_main_inst;
  logic [ADDR_W-1:0] r_main_pc;
  logic [INST_W-1:0] r_skid_inst;
  logic [ADDR_W-1:0] r_skid_pc;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [1:0]        r_occupancy;

  // Next-state values
  skid_state_e       w_state_nxt;
  logic [INST_W-1:0] w_main_inst_nxt;
  logic [ADDR_W-1:0] w_main_pc_nxt;
  logic [INST_W-1:0] w_skid_inst_nxt;
  logic [ADDR_W-1:0] w_skid_pc_nxt;

  // Handshakes use the registered ready/valid, never the raw state decode.
  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Next-state and slot update rules, with flush overriding all handshakes.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_inst_nxt = r_main_inst;
    w_main_pc_nxt   = r_main_pc;
    w_skid_inst_nxt = r_skid_inst;
    w_skid_pc_nxt   = r_skid_pc;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt     = ST_ONE;
          w_main_inst_nxt = in_inst;
          w_main_pc_nxt   = in_pc;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          // Head leaves and the new entry takes its place in the same cycle.
          w_state_nxt     = ST_ONE;
          w_main_inst_nxt = in_inst;
          w_main_pc_nxt   = in_pc;
        end else if (w_in_fire) begin
          // Downstream stalled: park the new entry behind the head.
          w_state_nxt     = ST_TWO;
          w_skid_inst_nxt = in_inst;
          w_skid_pc_nxt   = in_pc;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a pop can change anything.
        if (w_out_fire) begin
          w_state_nxt     = ST_ONE;
          w_main_inst_nxt = r_skid_inst;
          w_main_pc_nxt   = r_skid_pc;
          w_skid_inst_nxt = NOP_INST;
          w_skid_pc_nxt   = BUBBLE_PC;
        end else begin
          w_state_nxt = ST_TWO;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean empty stage.
        w_state_nxt     = ST_EMPTY;
        w_skid_inst_nxt = NOP_INST;
        w_skid_pc_nxt   = BUBBLE_PC;
      end
    endcase

    // An empty stage always presents a bubble so outputs stay deterministic.
    if (w_state_nxt == ST_EMPTY) begin
      w_main_inst_nxt = NOP_INST;
      w_main_pc_nxt   = BUBBLE_PC;
    end else begin
      w_main_inst_nxt = w_main_inst_nxt;
      w_main_pc_nxt   = w_main_pc_nxt;
    end

    // Redirect kills everything, including an entry handshaken this cycle.
    if (flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_inst_nxt = NOP_INST;
      w_main_pc_nxt   = BUBBLE_PC;
      w_skid_inst_nxt = NOP_INST;
      w_skid_pc_nxt   = BUBBLE_PC;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Single register update for state, both slots and the decoded flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_inst <= NOP_INST;
      r_main_pc   <= BUBBLE_PC;
      r_skid_inst <= NOP_INST;
      r_skid_pc   <= BUBBLE_PC;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_inst <= w_main_inst_nxt;
      r_main_pc   <= w_main_pc_nxt;
      r_skid_inst <= w_skid_inst_nxt;
      r_skid_pc   <= w_skid_pc_nxt;
      // Flags are decoded from the next state so they leave flops directly.
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      r_occupancy <= state_occupancy(w_state_nxt);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_inst  = r_main_inst;
  assign out_pc    = r_main_pc;
  assign occupancy = r_occupancy;

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, flow-controlled pipeline stage register for the five-stage CPU. It replaces the plain fetch/decode latch with a 2-entry skid buffer that carries `{inst, pc}` and has valid/ready handshakes on both sides. It adds stall back-pressure and flush (bubble insertion) while keeping full throughput. It is instantiated between IF and ID first, then reused at later stage boundaries.

## Interface
- Parameters:
  - `INST_W`, default 32: instruction width.
  - `ADDR_W`, default 32: PC width.
  - `NOP_INST`, default `32'h00000000`: bubble value written on reset/flush/empty.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous kill of all held entries (branch/jump redirect).
- `in_valid`  in  1  upstream holds a valid entry.
- `in_ready`  out  1  stage can accept; registered, a function of state only.
- `in_inst`  in  INST_W  instruction from upstream.
- `in_pc`  in  ADDR_W  PC of `in_inst`.
- `out_valid`  out  1  `out_inst`/`out_pc` are valid.
- `out_ready`  in  1  downstream accepts; deasserted means stall.
- `out_inst`  out  INST_W  head instruction.
- `out_pc`  out  ADDR_W  head PC.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main slot (drives outputs) and skid slot, each holding `{inst, pc}`.
- States:
  - EMPTY (occ 0)
  - ONE (main valid)
  - TWO (main and skid valid)
- Transitions:
  - EMPTY: `in_fire` → ONE, main ← in.
  - ONE:
    - `in_fire & out_fire` → ONE, main ← in.
    - `in_fire` only → TWO, skid ← in.
    - `out_fire` only → EMPTY.
    - Neither → hold.
  - TWO: `in_ready=0`. `out_fire` → ONE, main ← skid. Otherwise hold.
- Whenever the next state is EMPTY, main ← `{NOP_INST, 0}`. Outputs are therefore deterministic when `out_valid=0`.
- `in_ready = (state != TWO)`. `out_valid = (state != EMPTY)`. `occupancy` = state encoding.
- Ordering is strict FIFO; entries are never reordered, duplicated or dropped, except by flush.
- `flush`: next state EMPTY, main and skid ← `{NOP_INST, 0}`. Overrides any concurrent `in_fire`/`out_fire`.
  - An entry handshaken in the flush cycle is discarded. Upstream is redirected by the same flush.
  - An `out_fire` in the flush cycle still counts as consumed downstream.
- `rst` has priority over `flush`; it produces the same register values as flush.

## Timing
- Reset values:
  - `out_valid=0`, `in_ready=1`, `occupancy=0`.
  - `out_inst=NOP_INST`, `out_pc=0`.
- Latency: `in_fire` at cycle N → `out_valid=1` with that data at N+1.
- Throughput: one entry per cycle while `out_ready=1`. Occupancy stays ≤1 in that case.
- Stall: if `out_ready` drops, one further entry is absorbed into the skid slot. `in_ready` falls the next cycle, with no combinational path from `out_ready` to `in_ready`.
- Release: the first `out_fire` from TWO restores `in_ready=1` in the following cycle.
- No combinational path from any input to any output. All outputs come directly from registers.
- Flush at N → `out_valid=0`, `occupancy=0`, `in_ready=1` at N+1.
- `rst` asserted mid-operation: same result as flush at the next edge, regardless of state.

## Structure
- Shared CPU package/defines header holds:
  - `INST_W`/`ADDR_W` defaults
  - `NOP_INST`
  - the 2-bit state encoding: EMPTY=0, ONE=1, TWO=2
- A later EX/MEM instance reuses the same constants.
- No sub-module. A single always block updates state, main and skid. The small size does not justify a slot sub-module.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs → `out_valid=0`, `in_ready=1`, `out_inst=0`, `out_pc=0`, `occupancy=0`.
- Streaming: `out_ready=1`, push pc 0x0,0x4,0x8 with insts 0x11,0x22,0x33 on consecutive cycles → same sequence on outputs, each 1 cycle later, `occupancy≤1`.
- Stall: push 0x100 then 0x104 with `out_ready=0` → `occupancy=2`, `in_ready=0`, `out_pc=0x100`. Then `out_ready=1` → 0x100 then 0x104 delivered in order, `in_ready=1` one cycle after the first pop.
- Simultaneous pop/push in ONE: `out_ready=1`, `in_valid=1` held with pc 0x200,0x204 → `occupancy` stays 1, no drop.
- Flush: state TWO (0x300, 0x304) and `in_valid=1` (0x308) with `flush=1` for 1 cycle → next cycle `out_valid=0`, `occupancy=0`, `out_inst=NOP_INST`. 0x308 is never output.
- Reset over flush: `rst` and `flush` together while in TWO → reset values next cycle. An input pushed on the following cycle appears one cycle later.
